// File: rtl/ram_programmer.sv
// Loads WORDS bytes from a streaming source into the RAM stage over the shared bus.
// Each byte takes three cycles: accept, MAR load (MI), then RAM write (RI).
module ram_programmer #(
    parameter int WORDS  = 16,
    parameter int ADDR_W = 4
) (
    input  logic       clk,
    input  logic       clr,
    inout  wire  [7:0] bus,
    input  logic       prog_mode,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       MI,
    output logic       RI,
    output logic       cpu_hold,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        hold_q, hold_d;
    logic              abort_q, abort_d;
    logic              mi_q, mi_d;
    logic              ri_q, ri_d;
    logic              done_q, done_d;

    logic [7:0]        bus_val;
    logic              bus_oe;

    // A prog_mode drop seen in S_ADDR is remembered so the write still
    // finishes but the session is abandoned afterwards.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        hold_d  = hold_q;
        abort_d = abort_q;

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (!prog_mode) begin
                    addr_d = '0;
                end else if (data_valid) begin
                    hold_d  = data_in;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                abort_d = !prog_mode;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (abort_q || !prog_mode) begin
                    addr_d  = '0;
                    state_d = S_IDLE;
                end else if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (!prog_mode) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase

        mi_d   = (state_d == S_ADDR);
        ri_d   = (state_d == S_WRITE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            hold_q  <= '0;
            abort_q <= 1'b0;
            mi_q    <= 1'b0;
            ri_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            abort_q <= abort_d;
            mi_q    <= mi_d;
            ri_q    <= ri_d;
            done_q  <= done_d;
        end
    end

    // The bus is released while clr is asserted so a reset mid-step never fights the CPU.
    always_comb begin
        bus_val              = '0;
        bus_val[ADDR_W-1:0]  = addr_q;
        if (state_q == S_WRITE) begin
            bus_val = hold_q;
        end
        bus_oe = ((state_q == S_ADDR) || (state_q == S_WRITE)) && !clr;
    end

    assign bus        = bus_oe ? bus_val : 8'bz;
    assign MI         = mi_q;
    assign RI         = ri_q;
    assign done       = done_q;
    assign data_ready = (state_q == S_IDLE) && prog_mode;
    assign cpu_hold   = prog_mode || (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_programmer.sv
// Directed bench for ram_programmer with a small RAM-stage model hung off MI/RI/bus.
// The bus has pull-ups so a released bus reads back as 8'hFF.
module tb_ram_programmer;

    logic       clk = 1'b0;
    logic       clr;
    wire  [7:0] bus;
    logic       prog_mode;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       mi;
    logic       ri;
    logic       cpu_hold;
    logic       done;

    int checkCount = 0;
    int failCount  = 0;

    logic [7:0] ram [0:15];
    logic [3:0] mar;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 8; g++) begin : g_pullup
        pullup pu (bus[g]);
    end

    ram_programmer #(
        .WORDS  (16),
        .ADDR_W (4)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .bus        (bus),
        .prog_mode  (prog_mode),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .MI         (mi),
        .RI         (ri),
        .cpu_hold   (cpu_hold),
        .done       (done)
    );

    // RAM stage: MAR latches the low address bits on MI, RAM writes the bus on RI.
    always @(posedge clk) begin
        if (mi) mar <= bus[3:0];
        if (ri) ram[mar] <= bus;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic c, input logic pm, input logic dv,
                                 input logic [7:0] din);
        clr        = c;
        prog_mode  = pm;
        data_valid = dv;
        data_in    = din;
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] din);
        applyStimulus(1'b0, 1'b1, 1'b1, din);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int accepted;
        int lastReady;
        int badGap;
        int overlap;
        int miPulses;
        int riPulses;
        int extra;

        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        mar = 4'h0;

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("rst_mi", mi, 0);
        checkOutput("rst_ri", ri, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ready", data_ready, 0);
        checkOutput("rst_hold", cpu_hold, 0);
        checkOutput("rst_bus_hiz", bus, 8'hFF);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("pm_ready", data_ready, 1);
        checkOutput("pm_hold", cpu_hold, 1);

        // Single byte
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5);
        checkOutput("single_mi", mi, 1);
        checkOutput("single_ri_low", ri, 0);
        checkOutput("single_bus_addr", bus, 8'h00);
        checkOutput("single_busy", data_ready, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("single_ri", ri, 1);
        checkOutput("single_mi_low", mi, 0);
        checkOutput("single_bus_data", bus, 8'hA5);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("single_ready_again", data_ready, 1);
        checkOutput("single_bus_release", bus, 8'hFF);
        checkOutput("single_ram0", ram[0], 8'hA5);

        // Drop prog_mode for a cycle to return addr to 0, then stream 16 bytes
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        accepted  = 0;
        lastReady = 0;
        badGap    = 0;
        overlap   = 0;
        miPulses  = 0;
        riPulses  = 0;
        extra     = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            clr        = 1'b0;
            prog_mode  = 1'b1;
            data_valid = 1'b1;
            data_in    = 8'h10 + 8'(accepted);
            #2;
            if (mi && ri) overlap++;
            if (mi) miPulses++;
            if (ri) riPulses++;
            if (data_ready && accepted < 16) begin
                if (accepted > 0 && (cyc - lastReady) != 3) badGap++;
                lastReady = cyc;
                accepted++;
            end
            @(posedge clk);
            #1;
            if (accepted == 16) extra++;
            if (extra == 3) break;
        end
        checkOutput("load_accepted", accepted, 16);
        checkOutput("load_gap_errors", badGap, 0);
        checkOutput("load_overlap", overlap, 0);
        checkOutput("load_mi_pulses", miPulses, 16);
        checkOutput("load_ri_pulses", riPulses, 16);
        checkOutput("load_done", done, 1);
        checkOutput("load_ready_low", data_ready, 0);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("load_ram%0d", i), ram[i], 8'h10 + 8'(i));
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h55);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h55);
        checkOutput("done_held", done, 1);
        checkOutput("done_ready_low", data_ready, 0);
        checkOutput("done_no_mi", mi, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("done_cleared", done, 0);
        checkOutput("done_hold_released", cpu_hold, 0);

        // Abort during S_ADDR of the fifth byte
        for (int i = 0; i < 4; i++) sendByte(8'h30 + 8'(i));
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h34);
        checkOutput("abort_mi", mi, 1);
        checkOutput("abort_bus_addr", bus, 8'h04);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("abort_ri", ri, 1);
        checkOutput("abort_bus_data", bus, 8'h34);
        checkOutput("abort_hold_busy", cpu_hold, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("abort_ri_low", ri, 0);
        checkOutput("abort_bus_hiz", bus, 8'hFF);
        checkOutput("abort_hold_free", cpu_hold, 0);
        checkOutput("abort_ram4", ram[4], 8'h34);
        checkOutput("abort_ram3", ram[3], 8'h33);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h77);
        checkOutput("abort_addr_zero", bus, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("abort_ram0", ram[0], 8'h77);

        // Reset while in S_WRITE
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h99);
        checkOutput("rstw_bus_addr", bus, 8'h01);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("rstw_ri", ri, 1);
        clr = 1'b1;
        #1;
        checkOutput("rstw_bus_released", bus, 8'hFF);
        @(posedge clk);
        #1;
        checkOutput("rstw_mi", mi, 0);
        checkOutput("rstw_ri_low", ri, 0);
        checkOutput("rstw_done", done, 0);
        checkOutput("rstw_bus_hiz", bus, 8'hFF);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("rstw_ready", data_ready, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hC3);
        checkOutput("rstw_next_mi", mi, 1);
        checkOutput("rstw_next_addr", bus, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("rstw_next_data", bus, 8'hC3);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("rstw_ram0", ram[0], 8'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
